calculator_seq_multiplier: RTL
==============================

# calculator_seq_multiplier

Multi-cycle shift-and-add multiplier for the calculator datapath. It sits between the calculator data collector, which holds num1/num2, and the seven-segment answer display, which consumes the 32-bit product. It replaces the purely combinational 16x16 multiplier with a start/ready/done handshake. The stage selector pulses start when the answer stage is entered.

## Interface
- WIDTH, 16, operand width; product width is 2*WIDTH; iteration count is WIDTH.
- IN_clk  input  1  system clock; all state changes on its rising edge.
- IN_reset  input  1  asynchronous, active-high reset.
- IN_start  input  1  request a multiply; honoured only while OUT_ready=1.
- IN_A  input  WIDTH  multiplicand (num1), sampled only on an accepted start.
- IN_B  input  WIDTH  multiplier (num2), sampled only on an accepted start.
- OUT_product  output  2*WIDTH  last completed product; held until the next completion.
- OUT_ready  output  1  high only in IDLE; combinational decode of state.
- OUT_done  output  1  registered one-cycle pulse marking a new OUT_product.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - OUT_ready=1.
  - When IN_start=1 at a clock edge: capture IN_A and IN_B into internal operand registers, clear the 2*WIDTH accumulator, set the iteration counter to 0, go to BUSY.
- BUSY
  - Each edge: if the multiplier LSB is 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator.
  - Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
  - After iteration WIDTH-1 (counter = WIDTH-1 at that edge), go to DONE.
- DONE
  - Next edge: OUT_product <= accumulator result (sign-corrected, see Configuration), OUT_done <= 1, go to IDLE.
- OUT_done clears at the following edge.
- IN_start during BUSY or DONE is ignored. It is not queued.
- IN_A/IN_B changes after capture have no effect on the operation in flight.
- Arithmetic is exact. The accumulator is 2*WIDTH bits and cannot overflow for unsigned operands (max 0xFFFF*0xFFFF = 0xFFFE0001).
- Reset, asynchronous at any time including mid-BUSY/DONE:
  - state=IDLE, OUT_product=0, OUT_done=0, OUT_ready=1.
  - Accumulator, operand registers and counter = 0.
  - The operation in flight is discarded. No done pulse is generated for it.

## Timing
- Start sampled at edge 0.
- Iterations occur at edges 1..WIDTH; edge WIDTH enters DONE.
- OUT_product update and OUT_done=1 occur at edge WIDTH+1 (edge 17 for WIDTH=16). OUT_done is high for exactly one cycle.
- OUT_ready is low from just after edge 0 until just after edge WIDTH+1.
- The earliest next accepted start is edge WIDTH+2. Back-to-back throughput is one product per WIDTH+2 cycles.
- OUT_product is stable between completions. The display may read it at any time.
- IN_start held high continuously starts a new operation at every IDLE edge.

## Configuration
- SIGNED_MULT_EN defined:
  - IN_A and IN_B are two's complement.
  - At capture, the magnitudes are stored and the sign XOR is latched.
  - In DONE, the result is negated (two's complement, 2*WIDTH bits) if the XOR is 1.
  - The 0x8000 magnitude is treated as unsigned 0x8000, so -32768 * -32768 = 0x40000000.
  - Latency is unchanged.
- SIGNED_MULT_EN not defined:
  - Operands are unsigned.
  - No sign logic is present.

## Test plan
- Reset, then IN_A=0x0003, IN_B=0x0005, one-cycle start -> OUT_done pulses exactly 17 cycles after the start edge, OUT_product=0x0000000F, OUT_ready low for 17 cycles.
- Unsigned build, IN_A=IN_B=0xFFFF -> OUT_product=0xFFFE0001. Signed build, same operands -> OUT_product=0x00000001. Signed build, 0x8000*0x8000 -> 0x40000000. Signed build, 0xFFFE*0x0003 -> 0xFFFFFFFA.
- Start accepted with 0x1234*0x0010, then IN_A/IN_B changed to 0 and start pulsed again during BUSY -> a single done pulse, OUT_product=0x00012340, no second operation.
- IN_reset asserted at cycle 8 of BUSY -> OUT_product=0, OUT_done=0, OUT_ready=1 immediately (asynchronously). No done pulse follows. A new start of 2*7 completes with 0x0000000E.
- IN_start held high with operands 0x0000*0x1234 -> OUT_product=0 with done pulses every 18 cycles. OUT_product holds its value between pulses.
- Random sweep of 1000 operand pairs against a reference product, in both unsigned and SIGNED_MULT_EN builds -> all results match, latency always 17.

Source files
------------

// File: rtl/calculator_seq_multiplier_if.sv
// calculator_seq_multiplier_if: start/ready/done handshake and operand/product bus
// for the sequential multiplier.
`default_nettype none

interface calculator_seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 IN_start;
  logic [WIDTH-1:0]     IN_A;
  logic [WIDTH-1:0]     IN_B;
  logic [2*WIDTH-1:0]   OUT_product;
  logic                 OUT_ready;
  logic                 OUT_done;

  modport master (
    output IN_start, IN_A, IN_B,
    input  OUT_product, OUT_ready, OUT_done
  );

  modport slave (
    input  IN_start, IN_A, IN_B,
    output OUT_product, OUT_ready, OUT_done
  );
endinterface

`default_nettype wire

// File: rtl/calculator_seq_multiplier.sv
// +--------------------------------------------------------------------------+
// | calculator_seq_multiplier: shift-and-add WIDTH x WIDTH multiplier, WIDTH  |
// | iterations plus one DONE cycle. Optional signed mode: SIGNED_MULT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module calculator_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                         IN_clk,
  input  logic                         IN_reset,
  calculator_seq_multiplier_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  logic [WIDTH-1:0]     load_a;
  logic [WIDTH-1:0]     load_b;
  logic [2*WIDTH-1:0]   result;

`ifdef SIGNED_MULT_EN
  logic neg;

  // Magnitude of the most negative value wraps back to itself, which read
  // as unsigned is exactly the right magnitude.
  always_comb begin
    load_a = bus.IN_A[WIDTH-1] ? WIDTH'(-bus.IN_A) : bus.IN_A;
    load_b = bus.IN_B[WIDTH-1] ? WIDTH'(-bus.IN_B) : bus.IN_B;
    result = neg ? (2*WIDTH)'(-acc) : acc;
  end

  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      neg <= 1'b0;
    end else if (state == IDLE && bus.IN_start) begin
      neg <= bus.IN_A[WIDTH-1] ^ bus.IN_B[WIDTH-1];
    end
  end
`else
  always_comb begin
    load_a = bus.IN_A;
    load_b = bus.IN_B;
    result = acc;
  end
`endif

  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.IN_start) begin
            mcand  <= {{WIDTH{1'b0}}, load_a};
            mplier <= load_b;
            acc    <= '0;
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          product <= result;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.OUT_ready   = (state == IDLE);
  assign bus.OUT_product = product;
  assign bus.OUT_done    = done;

endmodule

`default_nettype wire
